// File: rtl/multi_ch_clk_div.sv
// multi_ch_clk_div: NUM_CH independent glitch-free integer clock dividers on one reference clock.
// Latency: an enable/ratio sampled at a period boundary (or on I_sync) takes effect on the next I_ref_clk edge.
// Backpressure: none; enable/ratio changes made mid-period are held off until the period completes.
//
// Ports:
//   I_ref_clk   reference clock, the only clock in the block
//   I_rst       asynchronous active-high reset
//   I_clk_en    per-channel enable, sampled only at a boundary or on I_sync
//   I_div_ratio packed ratios, channel c uses bits [c*WIDTH +: WIDTH]
//   I_sync      one-cycle strobe restarting every enabled channel in phase
//   O_div_clk   divided clock per channel (bypass: I_ref_clk)
//   O_tick      one-cycle pulse coincident with each O_div_clk rise
//   O_active    channel is dividing or bypassing
module multi_ch_clk_div #(
    parameter int WIDTH         = 8,
    parameter int NUM_CH        = 4,
    parameter bit GATE_WHEN_OFF = 1'b1
) (
    input  logic                    I_ref_clk,
    input  logic                    I_rst,
    input  logic [NUM_CH-1:0]       I_clk_en,
    input  logic [NUM_CH*WIDTH-1:0] I_div_ratio,
    input  logic                    I_sync,
    output logic [NUM_CH-1:0]       O_div_clk,
    output logic [NUM_CH-1:0]       O_tick,
    output logic [NUM_CH-1:0]       O_active
);

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_BYP = 2'd1,
        MODE_DIV = 2'd2
    } mode_e;

    typedef enum logic {
        PH_L = 1'b0,
        PH_H = 1'b1
    } phase_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] ratio_in;
        logic [WIDTH-1:0] ratio_q, ratio_d;
        mode_e            mode_q, mode_d;
        phase_e           phase_q, phase_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             div_q, div_d;
        logic [WIDTH-1:0] len_h;
        logic [WIDTH-1:0] len_l;
        logic             h_last;
        logic             l_last;
        logic             boundary;

        assign ratio_in = I_div_ratio[c*WIDTH +: WIDTH];

        // Odd ratios put the extra cycle in the high phase. For the maximum
        // ratio len_h is 2^(WIDTH-1), which still fits in WIDTH bits.
        assign len_h  = (ratio_q >> 1) + {{(WIDTH-1){1'b0}}, ratio_q[0]};
        assign len_l  = ratio_q >> 1;
        assign h_last = (cnt_q == len_h - ONE);
        assign l_last = (cnt_q == len_l - ONE);

        // Only OFF, BYP or the final low cycle may change mode or ratio. The
        // divided output is low (or about to rise with I_ref_clk) at all of
        // them, so the output mux never produces a runt pulse.
        assign boundary = (mode_q != MODE_DIV) || ((phase_q == PH_L) && l_last);

        always_ff @(posedge I_ref_clk or posedge I_rst) begin
            if (I_rst) begin
                ratio_q <= '0;
                mode_q  <= MODE_OFF;
                phase_q <= PH_L;
                cnt_q   <= '0;
                div_q   <= 1'b0;
            end else begin
                ratio_q <= ratio_d;
                mode_q  <= mode_d;
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
            end
        end

        always_comb begin
            ratio_d = ratio_q;
            mode_d  = mode_q;
            phase_d = phase_q;
            cnt_d   = cnt_q;
            div_d   = div_q;

            // I_sync forces the reload path regardless of where the channel is.
            if (I_sync || boundary) begin
                if (!I_clk_en[c]) begin
                    mode_d  = MODE_OFF;
                    phase_d = PH_L;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                end else if (ratio_in < TWO) begin
                    mode_d  = MODE_BYP;
                    ratio_d = ratio_in;
                    phase_d = PH_L;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                end else begin
                    mode_d  = MODE_DIV;
                    ratio_d = ratio_in;
                    phase_d = PH_H;
                    cnt_d   = '0;
                    div_d   = 1'b1;
                end
            end else if (phase_q == PH_H) begin
                if (h_last) begin
                    phase_d = PH_L;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        always_comb begin
            case (mode_q)
                MODE_DIV: O_div_clk[c] = div_q;
                MODE_BYP: O_div_clk[c] = I_ref_clk;
                default:  O_div_clk[c] = GATE_WHEN_OFF ? 1'b0 : I_ref_clk;
            endcase
        end

        assign O_tick[c]   = ((mode_q == MODE_DIV) && (phase_q == PH_H) && (cnt_q == '0))
                             || (mode_q == MODE_BYP);
        assign O_active[c] = (mode_q != MODE_OFF);
    end

endmodule

// File: tb/tb_multi_ch_clk_div.sv
// tb_multi_ch_clk_div: directed bench for multi_ch_clk_div, gated and pass-through variants.
// Inputs change just after the falling edge; outputs are sampled 1 time unit after each edge.
// A period-position model predicts every output; literal patterns pin the model.
module tb_multi_ch_clk_div;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic [N-1:0]   clk_en    = '0;
    logic [N*W-1:0] div_ratio = '0;
    logic           sync      = 1'b0;
    logic [N-1:0]   div_g, tick_g, act_g;
    logic [N-1:0]   div_p, tick_p, act_p;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_ch_clk_div #(.WIDTH(W), .NUM_CH(N), .GATE_WHEN_OFF(1'b1)) u_dut_gate (
        .I_ref_clk   (clk),
        .I_rst       (rst),
        .I_clk_en    (clk_en),
        .I_div_ratio (div_ratio),
        .I_sync      (sync),
        .O_div_clk   (div_g),
        .O_tick      (tick_g),
        .O_active    (act_g)
    );

    multi_ch_clk_div #(.WIDTH(W), .NUM_CH(N), .GATE_WHEN_OFF(1'b0)) u_dut_pass (
        .I_ref_clk   (clk),
        .I_rst       (rst),
        .I_clk_en    (clk_en),
        .I_div_ratio (div_ratio),
        .I_sync      (sync),
        .O_div_clk   (div_p),
        .O_tick      (tick_p),
        .O_active    (act_p)
    );

    // Model: each channel is OFF, BYP or DIV with a period R and a position
    // 0..R-1 inside it. The output is high for the first ceil(R/2) positions.
    localparam int M_OFF = 0;
    localparam int M_BYP = 1;
    localparam int M_DIV = 2;
    int m_mode [N] = '{default: 0};
    int m_r    [N] = '{default: 0};
    int m_pos  [N] = '{default: 0};
    int m_in;

    always @(posedge clk or posedge rst) begin
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_mode[c] = M_OFF;
                m_r[c]    = 0;
                m_pos[c]  = 0;
            end else if (sync || m_mode[c] != M_DIV || m_pos[c] == m_r[c] - 1) begin
                m_in = int'(div_ratio[c*W +: W]);
                if (!clk_en[c]) begin
                    m_mode[c] = M_OFF;
                end else if (m_in < 2) begin
                    m_mode[c] = M_BYP;
                end else begin
                    m_mode[c] = M_DIV;
                    m_r[c]    = m_in;
                    m_pos[c]  = 0;
                end
            end else begin
                m_pos[c] = m_pos[c] + 1;
            end
        end
    end

    function automatic logic [N-1:0] exp_div(input bit gate, input logic ck);
        logic [N-1:0] e;
        e = '0;
        for (int c = 0; c < N; c++) begin
            case (m_mode[c])
                M_DIV:   e[c] = (m_pos[c] < (m_r[c] + 1) / 2);
                M_BYP:   e[c] = ck;
                default: e[c] = gate ? 1'b0 : ck;
            endcase
        end
        return e;
    endfunction

    function automatic logic [N-1:0] exp_tick();
        logic [N-1:0] e;
        e = '0;
        for (int c = 0; c < N; c++)
            e[c] = (m_mode[c] == M_BYP) || (m_mode[c] == M_DIV && m_pos[c] == 0);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_act();
        logic [N-1:0] e;
        e = '0;
        for (int c = 0; c < N; c++)
            e[c] = (m_mode[c] != M_OFF);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT event at t=%0t", name, $time);
    endtask

    task automatic compare_all();
        chk("model_div_gated", 32'(div_g), 32'(exp_div(1'b1, clk)));
        chk("model_div_pass", 32'(div_p), 32'(exp_div(1'b0, clk)));
        chk("model_tick_gated", 32'(tick_g), 32'(exp_tick()));
        chk("model_tick_pass", 32'(tick_p), 32'(exp_tick()));
        chk("model_act_gated", 32'(act_g), 32'(exp_act()));
        chk("model_act_pass", 32'(act_p), 32'(exp_act()));
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1 compare_all();
            @(negedge clk);
            #1 compare_all();
        end
    end

    // Shift n falling-edge samples of one channel into v (first sample is MSB).
    // sel: 0 = gated div, 1 = gated tick, 2 = gated active
    task automatic cap_vec(input int sel, input int c, input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            case (sel)
                0:       v = (v << 1) | 32'(div_g[c]);
                1:       v = (v << 1) | 32'(tick_g[c]);
                default: v = (v << 1) | 32'(act_g[c]);
            endcase
        end
    endtask

    task automatic wait_tick(input int c);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (tick_g[c]) return;
        end
        timeout_fail("wait_tick");
    endtask

    // Length of the first high run and the low run after it.
    task automatic measure_runs(input int c, output int h, output int l);
        h = 0;
        l = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            #1;
            if (div_g[c]) begin
                if (l != 0) return;
                h++;
            end else if (h != 0) begin
                l++;
            end
        end
        timeout_fail("measure_runs");
    endtask

    task automatic set_ratio(input int c, input int r);
        div_ratio[c*W +: W] = W'(r);
    endtask

    logic [31:0] v, va;
    int h, l, coinc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_div_gated", 32'(div_g), 32'h0);
        chk("rst_div_pass_low", 32'(div_p), 32'h0);
        chk("rst_tick", 32'(tick_g), 32'h0);
        chk("rst_active", 32'(act_g), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_div_pass_high", 32'(div_p), 32'hf);
        @(negedge clk);
        #1 rst = 1'b0;

        // 1: ch0 R=4 from idle
        @(negedge clk);
        #1;
        clk_en[0] = 1'b1;
        set_ratio(0, 4);
        cap_vec(0, 0, 8, v);
        chk("r4_div_pattern", v, 32'b11001100);
        cap_vec(1, 0, 8, v);
        chk("r4_tick_pattern", v, 32'b10001000);

        // 2: ch1 R=5, ch3 R=255
        clk_en[1] = 1'b1;
        set_ratio(1, 5);
        cap_vec(0, 1, 10, v);
        chk("r5_div_pattern", v, 32'b1110011100);
        clk_en[3] = 1'b1;
        set_ratio(3, 255);
        measure_runs(3, h, l);
        chk("r255_high_len", 32'(h), 32'd128);
        chk("r255_low_len", 32'(l), 32'd127);

        // 3: ch0 R=4 -> R=6 written at H cycle 1
        wait_tick(0);
        @(negedge clk);
        #1 set_ratio(0, 6);
        cap_vec(0, 0, 14, v);
        chk("r4_to_r6_pattern", v, 32'b00111000111000);

        // 4: bypass with R=1, then R=0, then back to R=3
        set_ratio(0, 1);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                chk("byp_div_high", 32'(div_g[0]), 32'd1);
                chk("byp_tick", 32'(tick_g[0]), 32'd1);
                @(negedge clk);
                #1;
                chk("byp_div_low", 32'(div_g[0]), 32'd0);
                chk("byp_active", 32'(act_g[0]), 32'd1);
            end
            set_ratio(0, 0);
            repeat (2) @(negedge clk);
            #1;
        end
        set_ratio(0, 3);
        cap_vec(0, 0, 6, v);
        chk("byp_to_r3_pattern", v, 32'b110110);

        // 5: ch0 R=3 and ch1 R=6, then sync
        set_ratio(1, 6);
        repeat (13) @(negedge clk);
        #1 sync = 1'b1;
        @(negedge clk);
        #1 sync = 1'b0;
        chk("sync_first_ticks", {30'd0, tick_g[0], tick_g[1]}, 32'b11);
        coinc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            if (tick_g[0] && tick_g[1]) coinc++;
        end
        chk("sync_coincident_ticks", 32'(coinc), 32'd2);

        // 6: ch2 R=8 disabled at H cycle 1
        clk_en[2] = 1'b1;
        set_ratio(2, 8);
        wait_tick(2);
        @(negedge clk);
        #1 clk_en[2] = 1'b0;
        v  = '0;
        va = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            v  = (v << 1) | 32'(div_g[2]);
            va = (va << 1) | 32'(act_g[2]);
        end
        chk("disable_div_pattern", v, 32'b11000000);
        chk("disable_active_pattern", va, 32'b11111100);
        @(posedge clk);
        #1 chk("off_pass_follows_clk", 32'(div_p[2]), 32'd1);

        // Reset asserted while ch0 is high
        wait_tick(0);
        @(posedge clk);
        #2 chk("pre_rst_high", 32'(div_g[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_div_gated", 32'(div_g), 32'h0);
        chk("async_rst_div_pass", 32'(div_p), 32'hf);
        chk("async_rst_active", 32'(act_g), 32'h0);
        chk("async_rst_tick", 32'(tick_g), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
